// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-master RAM arbiter.
package ram_arb_pkg;

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } port_id_t;

    localparam int LOCK_MAX_DEF = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; masking for freeze and lock is done by the parent.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    input  logic force_m0,
    output logic gnt0,
    output logic gnt1
);

    port_id_t last_grant;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = (last_grant == M1);
                gnt1 = (last_grant == M0);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Marking M1 as last served makes M0 the winner of the next conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= M1;
        end else if (force_m0) begin
            last_grant <= M1;
        end else if (gnt0) begin
            last_grant <= M0;
        end else if (gnt1) begin
            last_grant <= M1;
        end
    end

endmodule

// File: rtl/avalon_ram_arbiter.sv
// Shares a single-port RAM between the fetch (m0) and data (m1) Avalon-MM ports.
// Define RAM_ARB_PERF_CNT_EN to build the conflict/lock performance counters.
module avalon_ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int BE_W     = DATA_W / 8,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic [ADDR_W+1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W+1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic              lock_timeout,
    output logic [31:0]       perf_conflict_cnt,
    output logic [31:0]       perf_lock_cnt
);

    localparam logic [8:0] LOCK_MAX_W = 9'(LOCK_MAX);

    arb_state_t state, state_nxt;
    logic [7:0] lock_cnt, lock_cnt_nxt;
    logic       lock_block, lock_block_nxt;
    logic       timeout_nxt;
    logic       req0, req1, req0_eff, arb_en;
    logic       gnt0, gnt1;
    logic       rd_pend;
    port_id_t   rd_owner;
    logic       unused_addr_lsb;

    assign req0     = m0_read;
    assign req1     = m1_read | m1_write;
    assign req0_eff = req0 && (state == OPEN);
    assign arb_en   = !freeze && !reset;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (reset),
        .en       (arb_en),
        .req0     (req0_eff),
        .req1     (req1),
        .force_m0 (timeout_nxt),
        .gnt0     (gnt0),
        .gnt1     (gnt1)
    );

    // After a forced release, lock_block keeps a still-held m1_lock from re-locking.
    always_comb begin
        state_nxt      = state;
        lock_cnt_nxt   = lock_cnt;
        lock_block_nxt = lock_block;
        timeout_nxt    = 1'b0;
        if (!m1_lock) begin
            lock_block_nxt = 1'b0;
        end
        if (!freeze) begin
            case (state)
                OPEN: begin
                    if (gnt1 && m1_lock && !lock_block) begin
                        state_nxt    = LOCKED;
                        lock_cnt_nxt = 8'd0;
                    end
                end
                LOCKED: begin
                    if (!m1_lock) begin
                        state_nxt    = OPEN;
                        lock_cnt_nxt = 8'd0;
                    end else if (({1'b0, lock_cnt} + 9'd1) >= LOCK_MAX_W) begin
                        state_nxt      = OPEN;
                        lock_cnt_nxt   = 8'd0;
                        timeout_nxt    = 1'b1;
                        lock_block_nxt = 1'b1;
                    end else begin
                        lock_cnt_nxt = lock_cnt + 8'd1;
                    end
                end
                default: state_nxt = OPEN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= OPEN;
            lock_cnt     <= 8'd0;
            lock_block   <= 1'b0;
            lock_timeout <= 1'b0;
            rd_pend      <= 1'b0;
            rd_owner     <= M0;
        end else begin
            state        <= state_nxt;
            lock_cnt     <= lock_cnt_nxt;
            lock_block   <= lock_block_nxt;
            lock_timeout <= timeout_nxt;
            rd_pend      <= gnt0 || (gnt1 && !m1_write);
            rd_owner     <= gnt1 ? M1 : M0;
        end
    end

    assign m0_waitrequest   = !gnt0;
    assign m1_waitrequest   = !gnt1;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = rd_pend && (rd_owner == M0);
    assign m1_readdatavalid = rd_pend && (rd_owner == M1);

    // A write wins over a simultaneous read on m1; the byte-address LSBs are dropped.
    assign ram_chipselect  = gnt0 | gnt1;
    assign ram_write       = gnt1 && m1_write;
    assign ram_address     = gnt1 ? m1_address[ADDR_W+1:2] : m0_address[ADDR_W+1:2];
    assign ram_byteenable  = ram_write ? m1_byteenable : {BE_W{1'b1}};
    assign ram_writedata   = m1_writedata;
    assign ram_clken       = 1'b1;
    assign unused_addr_lsb = ^{m0_address[1:0], m1_address[1:0]};

`ifdef RAM_ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt, lock_cyc_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= 32'd0;
            lock_cyc_cnt <= 32'd0;
        end else begin
            if (req0 && req1 && !freeze) begin
                conflict_cnt <= sat_inc(conflict_cnt);
            end
            if (state == LOCKED) begin
                lock_cyc_cnt <= sat_inc(lock_cyc_cnt);
            end
        end
    end

    assign perf_conflict_cnt = conflict_cnt;
    assign perf_lock_cnt     = lock_cyc_cnt;
`else
    assign perf_conflict_cnt = 32'd0;
    assign perf_lock_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_avalon_ram_arbiter.sv
// Scoreboard bench: stimulus pushes per-cycle and read-return expectations, a monitor checks them.
module tb_avalon_ram_arbiter;

`ifdef RAM_ARB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk, reset, freeze;
    logic [11:0] m0_address, m1_address;
    logic        m0_read, m1_read, m1_write, m1_lock;
    logic [3:0]  m1_byteenable;
    logic [31:0] m1_writedata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [9:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken, lock_timeout;
    logic [31:0] ram_writedata, ram_readdata, perf_conflict_cnt, perf_lock_cnt;

    avalon_ram_arbiter #(.ADDR_W(10), .DATA_W(32), .BE_W(4), .LOCK_MAX(4)) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
        .lock_timeout(lock_timeout), .perf_conflict_cnt(perf_conflict_cnt),
        .perf_lock_cnt(perf_lock_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered address, unregistered output; unwritten words hold a known pattern.
    logic [31:0] mem [0:1023];
    bit          written [0:1023];
    logic [9:0]  addr_q = 10'd0;
    logic [31:0] wr_base;

    function automatic logic [31:0] init_word(input logic [9:0] w);
        return (w == 10'd2) ? 32'h1122_3344 : (32'hA000_0000 | {22'd0, w});
    endfunction

    assign wr_base      = written[ram_address] ? mem[ram_address] : init_word(ram_address);
    assign ram_readdata = written[addr_q] ? mem[addr_q] : init_word(addr_q);

    always @(posedge clk) begin
        if (ram_chipselect) begin
            addr_q <= ram_address;
            if (ram_write) begin
                written[ram_address] <= 1'b1;
                for (int b = 0; b < 4; b++) begin
                    mem[ram_address][b*8 +: 8] <= ram_byteenable[b] ? ram_writedata[b*8 +: 8]
                                                                    : wr_base[b*8 +: 8];
                end
            end
        end
    end

    typedef struct {
        string       nm;
        bit          g0, g1, wr, lto, dv0, dv1, pchk;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata, pc, pl;
    } exp_t;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;
    bit   pchk_n = 1'b0;
    logic [31:0] pc_n = 32'd0, pl_n = 32'd0;

    task automatic set_in(input bit r0, input logic [11:0] a0, input bit r1, input bit w1,
                          input logic [11:0] a1, input logic [3:0] be, input logic [31:0] wd,
                          input bit lk);
        m0_read = r0; m0_address = a0; m1_read = r1; m1_write = w1; m1_address = a1;
        m1_byteenable = be; m1_writedata = wd; m1_lock = lk;
    endtask

    task automatic perf_expect(input logic [31:0] pc, input logic [31:0] pl);
        pchk_n = 1'b1;
        pc_n   = PERF ? pc : 32'd0;
        pl_n   = PERF ? pl : 32'd0;
    endtask

    task automatic push_rd(input bit port, input logic [31:0] data);
        rd_t r;
        r.port = port; r.data = data;
        rd_q.push_back(r);
    endtask

    // Expectations for the current cycle, then advance to just after the next rising edge.
    task automatic step(input string nm, input bit g0, input bit g1, input logic [9:0] addr,
                        input logic [3:0] be, input bit lto, input bit dv0, input bit dv1);
        exp_t e;
        e.nm = nm; e.g0 = g0; e.g1 = g1; e.wr = g1 && m1_write; e.addr = addr; e.be = be;
        e.wdata = m1_writedata; e.lto = lto; e.dv0 = dv0; e.dv1 = dv1;
        e.pchk = pchk_n; e.pc = pc_n; e.pl = pl_n;
        pchk_n = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    initial begin
        exp_t e;
        rd_t  r;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.nm, ".m0_waitrequest"}, {31'd0, m0_waitrequest}, {31'd0, !e.g0});
                chk({e.nm, ".m1_waitrequest"}, {31'd0, m1_waitrequest}, {31'd0, !e.g1});
                chk({e.nm, ".ram_chipselect"}, {31'd0, ram_chipselect}, {31'd0, e.g0 | e.g1});
                chk({e.nm, ".ram_write"}, {31'd0, ram_write}, {31'd0, e.wr});
                chk({e.nm, ".lock_timeout"}, {31'd0, lock_timeout}, {31'd0, e.lto});
                chk({e.nm, ".m0_readdatavalid"}, {31'd0, m0_readdatavalid}, {31'd0, e.dv0});
                chk({e.nm, ".m1_readdatavalid"}, {31'd0, m1_readdatavalid}, {31'd0, e.dv1});
                chk({e.nm, ".ram_clken"}, {31'd0, ram_clken}, 32'd1);
                if (e.g0 || e.g1) begin
                    chk({e.nm, ".ram_address"}, {22'd0, ram_address}, {22'd0, e.addr});
                    chk({e.nm, ".ram_byteenable"}, {28'd0, ram_byteenable}, {28'd0, e.be});
                end
                if (e.wr) chk({e.nm, ".ram_writedata"}, ram_writedata, e.wdata);
                if (e.pchk) begin
                    chk({e.nm, ".perf_conflict_cnt"}, perf_conflict_cnt, e.pc);
                    chk({e.nm, ".perf_lock_cnt"}, perf_lock_cnt, e.pl);
                end
            end
            if (m0_readdatavalid || m1_readdatavalid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_readdatavalid", 32'd1, 32'd0);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_owner", {31'd0, m1_readdatavalid}, {31'd0, r.port});
                    chk("m0_readdata", m0_readdata, r.data);
                    chk("m1_readdata", m1_readdata, r.data);
                end
            end
            if (done && exp_q.size() == 0) begin
                chk("reads_outstanding", rd_q.size(), 32'd0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        freeze = 1'b0;
        set_in(0, 12'h0, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        perf_expect(0, 0);
        step("reset", 0, 0, 10'h0, 4'h0, 0, 0, 0);

        // Single m0 read.
        reset = 1'b0;
        set_in(1, 12'h010, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        push_rd(0, 32'hA000_0004);
        step("t1_grant", 1, 0, 10'h004, 4'hF, 0, 0, 0);
        set_in(0, 12'h0, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        step("t1_ret", 0, 0, 10'h0, 4'h0, 0, 1, 0);

        // Alternating grants under continuous conflict.
        reset = 1'b1;
        perf_expect(0, 0);
        step("rst2", 0, 0, 10'h0, 4'h0, 0, 0, 0);
        reset = 1'b0;
        set_in(1, 12'h020, 1, 0, 12'h030, 4'h0, 32'h0, 0);
        push_rd(0, 32'hA000_0008);
        step("t2_c1", 1, 0, 10'h008, 4'hF, 0, 0, 0);
        set_in(1, 12'h024, 1, 0, 12'h037, 4'h0, 32'h0, 0);
        push_rd(1, 32'hA000_000D);
        step("t2_c2", 0, 1, 10'h00D, 4'hF, 0, 1, 0);
        set_in(1, 12'h028, 1, 0, 12'h038, 4'h0, 32'h0, 0);
        push_rd(0, 32'hA000_000A);
        step("t2_c3", 1, 0, 10'h00A, 4'hF, 0, 0, 1);
        set_in(1, 12'h02C, 1, 0, 12'h03C, 4'h0, 32'h0, 0);
        push_rd(1, 32'hA000_000F);
        step("t2_c4", 0, 1, 10'h00F, 4'hF, 0, 1, 0);
        set_in(0, 12'h0, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        perf_expect(4, 0);
        step("t2_tail", 0, 0, 10'h0, 4'h0, 0, 0, 1);

        // Byte-lane writes and read-back; write takes priority over read.
        set_in(0, 12'h0, 0, 1, 12'h008, 4'b0001, 32'h0000_00AB, 0);
        step("t3_wr", 0, 1, 10'h002, 4'b0001, 0, 0, 0);
        set_in(0, 12'h0, 1, 0, 12'h008, 4'h0, 32'h0, 0);
        push_rd(1, 32'h1122_33AB);
        step("t3_rd", 0, 1, 10'h002, 4'hF, 0, 0, 0);
        set_in(0, 12'h0, 1, 1, 12'h00C, 4'b1100, 32'hDEAD_BEEF, 0);
        step("t3_rdwr", 0, 1, 10'h003, 4'b1100, 0, 0, 1);
        set_in(0, 12'h0, 1, 0, 12'h00C, 4'h0, 32'h0, 0);
        push_rd(1, 32'hDEAD_0003);
        step("t3_rd2", 0, 1, 10'h003, 4'hF, 0, 0, 0);
        set_in(0, 12'h0, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        step("t3_tail", 0, 0, 10'h0, 4'h0, 0, 0, 1);

        // Lock held past LOCK_MAX=4 while m0 waits.
        set_in(0, 12'h0, 1, 0, 12'h050, 4'h0, 32'h0, 1);
        push_rd(1, 32'hA000_0014);
        step("t4_lock", 0, 1, 10'h014, 4'hF, 0, 0, 0);
        set_in(1, 12'h040, 1, 0, 12'h050, 4'h0, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            push_rd(1, 32'hA000_0014);
            step($sformatf("t4_locked%0d", i), 0, 1, 10'h014, 4'hF, 0, 0, 1);
        end
        push_rd(0, 32'hA000_0010);
        step("t4_release", 1, 0, 10'h010, 4'hF, 1, 0, 1);
        push_rd(1, 32'hA000_0014);
        step("t4_after1", 0, 1, 10'h014, 4'hF, 0, 1, 0);
        push_rd(0, 32'hA000_0010);
        step("t4_after2", 1, 0, 10'h010, 4'hF, 0, 0, 1);
        set_in(0, 12'h0, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        perf_expect(11, 4);
        step("t4_tail", 0, 0, 10'h0, 4'h0, 0, 1, 0);

        // Lock released by m1_lock deassertion.
        set_in(0, 12'h0, 1, 0, 12'h060, 4'h0, 32'h0, 1);
        push_rd(1, 32'hA000_0018);
        step("t4b_lock", 0, 1, 10'h018, 4'hF, 0, 0, 0);
        set_in(1, 12'h040, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        step("t4b_hold", 0, 0, 10'h0, 4'h0, 0, 0, 1);
        push_rd(0, 32'hA000_0010);
        step("t4b_open", 1, 0, 10'h010, 4'hF, 0, 0, 0);
        set_in(0, 12'h0, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        step("t4b_tail", 0, 0, 10'h0, 4'h0, 0, 1, 0);

        // Freeze blocks grants but lets the pending read complete.
        set_in(1, 12'h014, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        push_rd(0, 32'hA000_0005);
        step("t5_grant", 1, 0, 10'h005, 4'hF, 0, 0, 0);
        freeze = 1'b1;
        set_in(1, 12'h014, 1, 0, 12'h018, 4'h0, 32'h0, 0);
        step("t5_frz1", 0, 0, 10'h0, 4'h0, 0, 1, 0);
        step("t5_frz2", 0, 0, 10'h0, 4'h0, 0, 0, 0);
        freeze = 1'b0;
        push_rd(1, 32'hA000_0006);
        step("t5_resume", 0, 1, 10'h006, 4'hF, 0, 0, 0);
        set_in(0, 12'h0, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        perf_expect(12, 5);
        step("t5_tail", 0, 0, 10'h0, 4'h0, 0, 0, 1);

        // Reset with a read pending drops its return; m0 wins the first conflict afterwards.
        set_in(1, 12'h01C, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        step("t6_grant", 1, 0, 10'h007, 4'hF, 0, 0, 0);
        reset = 1'b1;
        set_in(1, 12'h024, 1, 0, 12'h02C, 4'h0, 32'h0, 0);
        perf_expect(0, 0);
        step("t6_reset", 0, 0, 10'h0, 4'h0, 0, 0, 0);
        reset = 1'b0;
        push_rd(0, 32'hA000_0009);
        step("t6_first", 1, 0, 10'h009, 4'hF, 0, 0, 0);
        set_in(0, 12'h0, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        done = 1'b1;
        step("t6_tail", 0, 0, 10'h0, 4'h0, 0, 1, 0);
    end

endmodule

// File: doc/avalon_ram_arbiter.md
Name: avalon_ram_arbiter

Overview:
- Shares the single-port on-chip RAM (1024 x 32, byte enables, address registered, output unregistered, read latency 1) between two Avalon-MM masters.
- Master 0 is the RISC-V instruction fetch port (read-only). Master 1 is the data port (read/write, optional lock for atomic read-modify-write).
- Sits between the core's two bus ports and the RAM slave. Performs round-robin arbitration, byte-to-word address conversion and readdatavalid generation.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- LOCK_MAX, 16, maximum consecutive locked cycles before the lock is forcibly released (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- freeze  in  1  block new grants while high
- m0_address  in  ADDR_W+2  byte address, fetch port
- m0_read  in  1  read request
- m0_waitrequest  out  1  request not accepted this cycle
- m0_readdata  out  DATA_W  read data
- m0_readdatavalid  out  1  read data valid
- m1_address  in  ADDR_W+2  byte address, data port
- m1_read  in  1  read request
- m1_write  in  1  write request
- m1_byteenable  in  BE_W  write byte lanes
- m1_writedata  in  DATA_W  write data
- m1_lock  in  1  hold grant for atomic sequence
- m1_waitrequest  out  1  request not accepted this cycle
- m1_readdata  out  DATA_W  read data
- m1_readdatavalid  out  1  read data valid
- ram_address  out  ADDR_W  word address to RAM
- ram_byteenable  out  BE_W  byte enables to RAM
- ram_chipselect  out  1  RAM access this cycle
- ram_write  out  1  RAM write strobe
- ram_writedata  out  DATA_W  write data to RAM
- ram_clken  out  1  RAM clock enable
- ram_readdata  in  DATA_W  RAM output (valid the cycle after address)
- lock_timeout  out  1  one-cycle pulse on forced lock release
- perf_conflict_cnt  out  32  performance counter (see Optional Feature)
- perf_lock_cnt  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset values:
  - waitrequests 1; readdatavalids 0; lock_timeout 0; perf counters 0.
  - ram_chipselect 0 and ram_write 0.
  - last_grant=1, so m0 wins the first conflict.
  - State OPEN; lock counter 0.
- Grant is combinational, at most one per cycle, never while freeze=1.
  - Winner sees waitrequest=0 in the request cycle. The loser, or any requester during freeze, sees 1.
  - Idle masters see waitrequest=1.
- RAM drive:
  - ram_chipselect=1 only in a grant cycle.
  - ram_address = winner address[ADDR_W+1:2]; byte address bits [1:0] are ignored.
  - ram_write = winner write.
  - ram_byteenable = m1_byteenable for m1 writes, all-ones otherwise.
  - ram_clken is constant 1.
- Request priority: m1_write wins over m1_read if both are asserted.
- Read return:
  - A granted read sets register rd_pend and records the owner.
  - The next cycle, the owner's readdatavalid=1 and readdata=ram_readdata.
  - Throughput is one read per cycle, fully pipelined.
  - Both mX_readdata outputs always carry ram_readdata; only readdatavalid differs.
- Round-robin arbitration:
  - When both masters request, grant the port that is not last_grant.
  - last_grant updates on every grant.
  - A single requester always wins.
- States:
  - OPEN -> LOCKED when m1 is granted with m1_lock=1.
  - LOCKED: only m1 may be granted, and the lock counter increments each cycle.
  - LOCKED -> OPEN when m1_lock=0 at a clock edge, or when the counter reaches LOCK_MAX. The LOCK_MAX release pulses lock_timeout for one cycle and forces last_grant=1 (m0 next).
  - After a timeout release, m1_lock is ignored until it is deasserted for at least one cycle.
- freeze:
  - Outstanding rd_pend still completes.
  - The state and lock counter hold.
- Reset mid-operation: all registers clear immediately. A pending readdatavalid is dropped, not delivered.

Optional Feature:
- Macro: RAM_ARB_PERF_CNT_EN.
- Defined:
  - perf_conflict_cnt increments each cycle both masters request (freeze=0).
  - perf_lock_cnt increments each LOCKED cycle.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both outputs are tied to 0, with no counter logic. Ports remain present for stable integration.

Decomposition:
- Package ram_arb_pkg:
  - state enum {OPEN, LOCKED}
  - port-id typedef (1 bit: M0=0, M1=1)
  - localparam for default LOCK_MAX
- Sub-module rr_arb2: 2-input round-robin grant with last_grant register and enable input (freeze/lock masking applied by the parent).

Test Plan:
1. m0_read addr 12'h010 alone -> same cycle m0_waitrequest=0, ram_address=10'h004. Next cycle m0_readdatavalid=1 with the RAM word at 0x004.
2. Both masters read every cycle after reset -> grants m0,m1,m0,m1. Each readdatavalid is one cycle after its grant. perf_conflict_cnt=4 after 4 cycles (macro on).
3. m1_write addr 12'h008 data 32'h0000_00AB be=4'b0001 onto a word holding 32'h1122_3344, then m1_read -> m1_readdata=32'h1122_33AB.
4. LOCK_MAX=4: m1 holds lock and requests continuously while m0 requests -> m0 stalled 4 cycles, lock_timeout pulse, m0 granted on the next cycle.
5. freeze raised in the cycle after an m0 read grant -> m0_readdatavalid still asserted. No grants while freeze=1; grants resume the cycle freeze=0.
6. reset asserted while rd_pend=1 -> readdatavalid immediately 0. After release, a simultaneous request is granted to m0.
